// File: rtl/j1_io_fabric_if.sv
// j1_io_fabric_if
// ---------------
// Purpose: the J1 CPU I/O bus between the core and the I/O fabric.
//
// Signals:
//   io_addr  16  I/O address from the core
//   io_rd     1  read strobe
//   io_wr     1  write strobe
//   io_dout  16  write data from the core
//   io_din   16  read data back to the core (combinational in the fabric)
//
// Modports:
//   master  the J1 core side (drives address, strobes and write data)
//   slave   the fabric side (drives read data)
interface j1_io_fabric_if;
    logic [15:0] io_addr;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_dout;
    logic [15:0] io_din;

    modport master (
        output io_addr,
        output io_rd,
        output io_wr,
        output io_dout,
        input  io_din
    );

    modport slave (
        input  io_addr,
        input  io_rd,
        input  io_wr,
        input  io_dout,
        output io_din
    );
endinterface

// File: rtl/j1_io_fabric.sv
// j1_io_fabric
// ------------
// Purpose: I/O interconnect for the J1 SoC. It decodes 256-word address pages
// onto NUM_SLOTS peripheral slots and returns the selected slot's read data.
// It also provides a control page with:
//   - a sticky unmapped-access error flag plus first-error address capture;
//   - a maskable, rising-edge-latched interrupt aggregator.
//
// Optional feature macro: IO_FABRIC_IRQ_EN. When it is undefined:
//   - the interrupt logic is not built;
//   - irq is tied 0;
//   - the mask, pending and id registers read 0 and ignore writes.
//
// Ports:
//   sys_clk_i   in   1              system clock, rising edge
//   sys_rst_i   in   1              asynchronous active-high reset
//   bus         slave modport       J1 I/O bus (addr, rd, wr, dout, din)
//   slot_cs     out  NUM_SLOTS      one-hot slot select (combinational)
//   slot_rdata  in   16*NUM_SLOTS   slot read data, slot i at [16i+15:16i]
//   slot_irq    in   NUM_SLOTS      level interrupt requests (sys_clk_i domain)
//   irq         out  1              aggregated interrupt
//   err         out  1              sticky unmapped-access flag
//
// Control page (CTRL_PAGE, offset = io_addr[3:0]):
//   0x0  ID        {8'hA5, NUM_SLOTS}
//   0x2  ERR_ADDR  address of the first unmapped access
//   0x4  STATUS    bit0 err (write 1 to clear), bit1 irq
//   0x6  IRQ_MASK
//   0x8  IRQ_PEND  write 1 to clear
//   0xA  IRQ_ID    lowest active interrupt index, or 16'hFFFF if none
module j1_io_fabric #(
    parameter int          NUM_SLOTS     = 16,
    parameter logic [7:0]  BASE_PAGE     = 8'h60,
    parameter logic [7:0]  CTRL_PAGE     = 8'h5F,
    parameter logic [15:0] DEFAULT_RDATA = 16'h0666
) (
    input  logic                    sys_clk_i,
    input  logic                    sys_rst_i,
    j1_io_fabric_if.slave           bus,
    output logic [NUM_SLOTS-1:0]    slot_cs,
    input  logic [16*NUM_SLOTS-1:0] slot_rdata,
    input  logic [NUM_SLOTS-1:0]    slot_irq,
    output logic                    irq,
    output logic                    err
);

    localparam logic [3:0] OFF_ID     = 4'h0;
    localparam logic [3:0] OFF_ERRADR = 4'h2;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_MASK   = 4'h6;
    localparam logic [3:0] OFF_PEND   = 4'h8;
    localparam logic [3:0] OFF_IRQID  = 4'hA;

    logic [7:0]  page;
    logic [3:0]  offset;
    logic        slot_hit;
    logic        ctrl_sel;
    logic        ctrl_wr;
    logic        unmapped;
    logic [15:0] slot_data;
    logic [15:0] ctrl_rdata;

    logic        err_q,      err_d;
    logic [15:0] err_addr_q, err_addr_d;
    logic        err_clr;

    logic [15:0] mask_rd;
    logic [15:0] pend_rd;
    logic [15:0] irq_id_rd;

    assign page     = bus.io_addr[15:8];
    assign offset   = bus.io_addr[3:0];
    assign ctrl_sel = (page == CTRL_PAGE);
    assign ctrl_wr  = bus.io_wr & ctrl_sel;
    assign slot_hit = |slot_cs;
    assign unmapped = (bus.io_rd | bus.io_wr) & ~slot_hit & ~ctrl_sel;

    // Slot decode: page arithmetic is done in 8 bits so the slot range
    // behaves exactly like the page compare the CPU software expects.
    always_comb begin
        slot_cs   = '0;
        slot_data = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (page == 8'(BASE_PAGE + 8'(i))) begin
                slot_cs[i] = 1'b1;
                slot_data  = slot_rdata[16*i +: 16];
            end
        end
    end

    // Error capture: ERR_ADDR only follows a new error while err is clear,
    // or while it is being cleared in the same cycle, so the first error
    // of an episode is the one software sees.
    always_comb begin
        err_clr    = ctrl_wr & (offset == OFF_STATUS) & bus.io_dout[0];
        err_d      = unmapped | (err_q & ~err_clr);
        err_addr_d = err_addr_q;
        if (unmapped && (!err_q || err_clr)) begin
            err_addr_d = bus.io_addr;
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err = err_q;

`ifdef IO_FABRIC_IRQ_EN
    logic [NUM_SLOTS-1:0] irq_sync_q;
    logic [NUM_SLOTS-1:0] pend_q, pend_d;
    logic [NUM_SLOTS-1:0] mask_q, mask_d;
    logic [NUM_SLOTS-1:0] active;

    // Pending bits latch rising edges of slot_irq; the set term is OR-ed in
    // after the write-1-to-clear so a coincident edge is never lost.
    always_comb begin
        mask_d = mask_q;
        pend_d = pend_q;
        if (ctrl_wr && (offset == OFF_MASK)) begin
            mask_d = bus.io_dout[NUM_SLOTS-1:0];
        end
        if (ctrl_wr && (offset == OFF_PEND)) begin
            pend_d = pend_q & ~bus.io_dout[NUM_SLOTS-1:0];
        end
        pend_d = pend_d | (slot_irq & ~irq_sync_q);
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            irq_sync_q <= '0;
            pend_q     <= '0;
            mask_q     <= '0;
        end else begin
            irq_sync_q <= slot_irq;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
        end
    end

    // Priority encoder: scanning downward leaves the lowest active index.
    always_comb begin
        active    = pend_q & mask_q;
        irq_id_rd = 16'hFFFF;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (active[i]) begin
                irq_id_rd = 16'(i);
            end
        end
    end

    assign irq     = |active;
    assign mask_rd = 16'(mask_q);
    assign pend_rd = 16'(pend_q);
`else
    logic unused_irq_inputs;

    assign unused_irq_inputs = ^slot_irq;
    assign irq       = 1'b0;
    assign mask_rd   = '0;
    assign pend_rd   = '0;
    assign irq_id_rd = '0;
`endif

    // Control page read mux; unlisted offsets read 0.
    always_comb begin
        ctrl_rdata = '0;
        case (offset)
            OFF_ID:     ctrl_rdata = {8'hA5, 8'(NUM_SLOTS)};
            OFF_ERRADR: ctrl_rdata = err_addr_q;
            OFF_STATUS: ctrl_rdata = {14'd0, irq, err_q};
            OFF_MASK:   ctrl_rdata = mask_rd;
            OFF_PEND:   ctrl_rdata = pend_rd;
            OFF_IRQID:  ctrl_rdata = irq_id_rd;
            default:    ctrl_rdata = '0;
        endcase
    end

    // Read return: a slot page wins, then the control page, then the
    // default pattern that makes unmapped reads easy to spot.
    always_comb begin
        bus.io_din = DEFAULT_RDATA;
        if (slot_hit) begin
            bus.io_din = slot_data;
        end else if (ctrl_sel) begin
            bus.io_din = ctrl_rdata;
        end
    end

    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.io_addr[7:4], bus.io_dout};

endmodule

// File: tb/tb_j1_io_fabric.sv
// tb_j1_io_fabric
// ---------------
// Self-checking bench for j1_io_fabric. A 16-slot instance is exercised by
// directed sequences followed by random traffic and compared against a
// behavioural model of the fabric registers. A 5-slot instance covers the
// ID register and the slot range limit. The interrupt checks are compiled
// in only when IO_FABRIC_IRQ_EN is defined.
module tb_j1_io_fabric;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // 16-slot instance
    j1_io_fabric_if bus();
    logic [15:0]  slot_cs;
    logic [255:0] slot_rdata;
    logic [15:0]  slot_irq;
    logic         irq;
    logic         err;

    // 5-slot instance
    j1_io_fabric_if bus5();
    logic [4:0]   cs5;
    logic [79:0]  rdata5;
    logic [4:0]   sirq5;
    logic         irq5;
    logic         err5;

    j1_io_fabric #(.NUM_SLOTS(16)) dut (
        .sys_clk_i  (clk),
        .sys_rst_i  (rst),
        .bus        (bus),
        .slot_cs    (slot_cs),
        .slot_rdata (slot_rdata),
        .slot_irq   (slot_irq),
        .irq        (irq),
        .err        (err)
    );

    j1_io_fabric #(.NUM_SLOTS(5)) dut5 (
        .sys_clk_i  (clk),
        .sys_rst_i  (rst),
        .bus        (bus5),
        .slot_cs    (cs5),
        .slot_rdata (rdata5),
        .slot_irq   (sirq5),
        .irq        (irq5),
        .err        (err5)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [15:0] sdat [16];
    bit          m_err;
    bit   [15:0] m_ea;
    bit   [15:0] m_pend;
    bit   [15:0] m_mask;
    bit   [15:0] m_prev;

    function automatic bit is_slot(input logic [15:0] a);
        return (a[15:8] >= 8'h60) && (a[15:8] <= 8'h6F);
    endfunction

    function automatic logic [15:0] exp_cs(input logic [15:0] a);
        if (is_slot(a)) return 16'd1 << (a[15:8] - 8'h60);
        return 16'd0;
    endfunction

    function automatic logic exp_irq();
        return |(m_pend & m_mask);
    endfunction

    function automatic logic [15:0] exp_id();
`ifdef IO_FABRIC_IRQ_EN
        for (int i = 0; i < 16; i++) begin
            if (m_pend[i] && m_mask[i]) return 16'(i);
        end
        return 16'hFFFF;
`else
        return 16'h0000;
`endif
    endfunction

    function automatic logic [15:0] exp_din(input logic [15:0] a);
        if (is_slot(a)) return sdat[a[15:8] - 8'h60];
        if (a[15:8] == 8'h5F) begin
            case (a[3:0])
                4'h0:    return 16'hA510;
                4'h2:    return m_ea;
                4'h4:    return {14'd0, exp_irq(), m_err};
                4'h6:    return m_mask;
                4'h8:    return m_pend;
                4'hA:    return exp_id();
                default: return 16'h0000;
            endcase
        end
        return 16'h0666;
    endfunction

    // Advances the model by one clock edge with the given bus activity.
    task automatic modelEdge(input logic [15:0] a, input bit r, input bit w,
                             input logic [15:0] d, input logic [15:0] si);
        bit unm;
        bit ctrl;
        bit clr;
        ctrl = (a[15:8] == 8'h5F);
        unm  = (r || w) && !is_slot(a) && !ctrl;
        clr  = w && ctrl && (a[3:0] == 4'h4) && d[0];
        if (unm && (!m_err || clr)) m_ea = a;
        m_err = unm || (m_err && !clr);
`ifdef IO_FABRIC_IRQ_EN
        if (w && ctrl && (a[3:0] == 4'h8)) m_pend = m_pend & ~d;
        m_pend = m_pend | (si & ~m_prev);
        if (w && ctrl && (a[3:0] == 4'h6)) m_mask = d;
        m_prev = si;
`endif
    endtask

    task automatic modelReset();
        m_err  = 1'b0;
        m_ea   = '0;
        m_pend = '0;
        m_mask = '0;
        m_prev = '0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic packSlots();
        for (int i = 0; i < 16; i++) slot_rdata[16*i +: 16] = sdat[i];
    endtask

    // One bus cycle: drive at the falling edge, check the combinational
    // read path before the rising edge, then check registered flags after.
    task automatic applyStimulus(input logic [15:0] a, input bit r, input bit w,
                                 input logic [15:0] d, input logic [15:0] si);
        @(negedge clk);
        bus.io_addr = a;
        bus.io_rd   = r;
        bus.io_wr   = w;
        bus.io_dout = d;
        slot_irq    = si;
        packSlots();
        #1;
        checkOutput("io_din", bus.io_din, exp_din(a));
        checkOutput("slot_cs", slot_cs, exp_cs(a));
        @(posedge clk);
        modelEdge(a, r, w, d, si);
        #1;
        checkOutput("err", err, m_err);
        checkOutput("irq", irq, exp_irq());
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] si;

        rst         = 1'b1;
        bus.io_addr = '0;
        bus.io_rd   = 1'b0;
        bus.io_wr   = 1'b0;
        bus.io_dout = '0;
        slot_irq    = '0;
        bus5.io_addr = '0;
        bus5.io_rd   = 1'b0;
        bus5.io_wr   = 1'b0;
        bus5.io_dout = '0;
        sirq5        = '0;
        rdata5       = '0;
        rdata5[79:64] = 16'h4444;
        for (int i = 0; i < 16; i++) sdat[i] = 16'h1000 + 16'(i);
        packSlots();
        modelReset();
        #3;
        checkOutput("reset_err", err, 1'b0);
        checkOutput("reset_irq", irq, 1'b0);
        #9 rst = 1'b0;
        $display("[TB] reset released");

        // Decode sweep across all sixteen slot pages
        for (int i = 0; i < 16; i++) begin
            applyStimulus({8'h60 + 8'(i), 8'h00}, 1'b1, 1'b0, 16'h0, 16'h0);
            checkOutput("sweep_din", bus.io_din, 16'h1000 + 16'(i));
            checkOutput("sweep_cs", slot_cs, 16'd1 << i);
        end
        applyStimulus(16'h7000, 1'b1, 1'b0, 16'h0, 16'h0);
        checkOutput("page70_din", bus.io_din, 16'h0666);
        checkOutput("page70_cs", slot_cs, 16'h0);
        checkOutput("page70_err", err, 1'b1);

        // Error capture: clear, then two unmapped accesses keep the first
        applyStimulus(16'h5F04, 1'b0, 1'b1, 16'h0001, 16'h0);
        checkOutput("clear_err", err, 1'b0);
        applyStimulus(16'h8004, 1'b1, 1'b0, 16'h0, 16'h0);
        applyStimulus(16'h9000, 1'b0, 1'b1, 16'h1234, 16'h0);
        checkOutput("err_set", err, 1'b1);
        applyStimulus(16'h5F02, 1'b1, 1'b0, 16'h0, 16'h0);
        checkOutput("err_addr", bus.io_din, 16'h8004);
        applyStimulus(16'h5F04, 1'b1, 1'b0, 16'h0, 16'h0);
        checkOutput("status_err", bus.io_din, 16'h0001);
        applyStimulus(16'h5F04, 1'b0, 1'b1, 16'h0001, 16'h0);
        checkOutput("err_cleared", err, 1'b0);
        applyStimulus(16'hA0C3, 1'b1, 1'b0, 16'h0, 16'h0);
        applyStimulus(16'h5F02, 1'b1, 1'b0, 16'h0, 16'h0);
        checkOutput("err_recapture", bus.io_din, 16'hA0C3);

        // Five-slot instance: ID value and slot range limit
        @(negedge clk);
        bus5.io_addr = 16'h5F00;
        bus5.io_rd   = 1'b1;
        #1;
        checkOutput("id5", bus5.io_din, 16'hA505);
        bus5.io_addr = 16'h6400;
        #1;
        checkOutput("slot4_din", bus5.io_din, 16'h4444);
        checkOutput("slot4_cs", cs5, 5'b10000);
        @(negedge clk);
        bus5.io_addr = 16'h6500;
        #1;
        checkOutput("page65_din", bus5.io_din, 16'h0666);
        checkOutput("page65_cs", cs5, 5'b00000);
        @(posedge clk);
        #1;
        checkOutput("page65_err", err5, 1'b1);
        checkOutput("irq5", irq5, 1'b0);
        bus5.io_rd = 1'b0;

`ifdef IO_FABRIC_IRQ_EN
        // Interrupt aggregation with slot 2 unmasked
        applyStimulus(16'h5F06, 1'b0, 1'b1, 16'h0004, 16'h0);
        applyStimulus(16'h5F08, 1'b1, 1'b0, 16'h0, 16'h0004);
        checkOutput("irq_s2", irq, 1'b1);
        applyStimulus(16'h5F0A, 1'b1, 1'b0, 16'h0, 16'h0004);
        checkOutput("irq_id2", bus.io_din, 16'h0002);
        applyStimulus(16'h5F08, 1'b1, 1'b0, 16'h0, 16'h0005);
        applyStimulus(16'h5F08, 1'b1, 1'b0, 16'h0, 16'h0005);
        checkOutput("pend5", bus.io_din, 16'h0005);
        applyStimulus(16'h5F0A, 1'b1, 1'b0, 16'h0, 16'h0005);
        checkOutput("irq_id_still2", bus.io_din, 16'h0002);
        applyStimulus(16'h5F08, 1'b0, 1'b1, 16'h0004, 16'h0005);
        checkOutput("irq_w1c", irq, 1'b0);

        // Held level does not re-arm; coincident edge beats the clear
        applyStimulus(16'h5F06, 1'b0, 1'b1, 16'h0008, 16'h0008);
        checkOutput("irq_s3", irq, 1'b1);
        applyStimulus(16'h5F08, 1'b0, 1'b1, 16'h0008, 16'h0008);
        applyStimulus(16'h5F08, 1'b1, 1'b0, 16'h0, 16'h0008);
        checkOutput("held_level", bus.io_din, 16'h0001);
        applyStimulus(16'h5F08, 1'b1, 1'b0, 16'h0, 16'h0000);
        applyStimulus(16'h5F08, 1'b0, 1'b1, 16'h0008, 16'h0008);
        applyStimulus(16'h5F08, 1'b1, 1'b0, 16'h0, 16'h0008);
        checkOutput("set_wins", bus.io_din, 16'h0009);

        // Everything pending and unmasked before the reset check
        applyStimulus(16'h5F06, 1'b0, 1'b1, 16'hFFFF, 16'h0000);
        applyStimulus(16'h5F08, 1'b1, 1'b0, 16'h0, 16'hFFFF);
        checkOutput("pend_all", bus.io_din, 16'hFFFF);
`else
        // Interrupt logic absent: irq stays low and its registers read 0
        applyStimulus(16'h5F06, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
        applyStimulus(16'h5F06, 1'b1, 1'b0, 16'h0, 16'h0000);
        checkOutput("mask_absent", bus.io_din, 16'h0000);
        applyStimulus(16'h5F0A, 1'b1, 1'b0, 16'h0, 16'hFFFF);
        checkOutput("irqid_absent", bus.io_din, 16'h0000);
        checkOutput("irq_absent", irq, 1'b0);
`endif

        // Asynchronous reset mid-cycle
        applyStimulus(16'h8004, 1'b1, 1'b0, 16'h0, slot_irq);
        checkOutput("pre_reset_err", err, 1'b1);
        #2 rst = 1'b1;
        slot_irq = '0;
        #1;
        checkOutput("async_err", err, 1'b0);
        checkOutput("async_irq", irq, 1'b0);
        bus.io_addr = 16'h5F08;
        #1;
        checkOutput("async_pend", bus.io_din, 16'h0000);
        bus.io_addr = 16'h5F06;
        #1;
        checkOutput("async_mask", bus.io_din, 16'h0000);
        bus.io_addr = 16'h5F02;
        #1;
        checkOutput("async_erraddr", bus.io_din, 16'h0000);
        rst = 1'b0;
        modelReset();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0: a = {8'h5F, 4'h0, 4'($urandom_range(0, 7) * 2)};
                1: a = {8'h60 + 8'($urandom_range(0, 15)), 8'($urandom)};
                2: a = 16'($urandom);
                default: a = {8'h5F, 8'($urandom)};
            endcase
            si = 16'($urandom);
            for (int i = 0; i < 16; i++) sdat[i] = 16'($urandom);
            applyStimulus(a, 1'($urandom), 1'($urandom), 16'($urandom), si);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/j1_io_fabric.md
# j1_io_fabric

Parametrised I/O interconnect for the J1 SoC: it replaces the fixed chip-select decoder and read multiplexer in the SoC top. It decodes 256-word address pages onto NUM_SLOTS peripheral slots and returns the selected slot's read data to the CPU. It also provides its own control page with a sticky unmapped-access error capture and a maskable, edge-latched interrupt aggregator. It sits between the j1 core I/O port and all peripheral_* instances.

## Interface
Parameters:
- NUM_SLOTS, 16: number of peripheral slots, legal range 1..16.
- BASE_PAGE, 8'h60: slot i is decoded at page BASE_PAGE+i.
- CTRL_PAGE, 8'h5F: page of the fabric's own registers. It must lie outside the slot pages.
- DEFAULT_RDATA, 16'h0666: read data returned for an unmapped page.

Ports:
- sys_clk_i  in  1  system clock; all state is on its rising edge.
- sys_rst_i  in  1  asynchronous, active-high reset.
- io_addr  in  16  J1 I/O address.
- io_rd  in  1  J1 read strobe.
- io_wr  in  1  J1 write strobe.
- io_dout  in  16  J1 write data.
- io_din  out  16  read data to J1 (combinational).
- slot_cs  out  NUM_SLOTS  one-hot slot select (combinational).
- slot_rdata  in  16*NUM_SLOTS  slot read data; slot i occupies bits [16i+15:16i].
- slot_irq  in  NUM_SLOTS  level interrupt request from each slot, synchronous to sys_clk_i.
- irq  out  1  aggregated interrupt.
- err  out  1  sticky unmapped-access flag.

## Operation
Decode:
- page = io_addr[15:8].
- slot_cs[i] = (page == BASE_PAGE+i) for i < NUM_SLOTS, independent of the strobes. At most one bit is ever set.
- io_din is selected in this order:
  - slot_rdata of the selected slot;
  - otherwise the control register if page == CTRL_PAGE;
  - otherwise DEFAULT_RDATA.

Unmapped access:
- An access is unmapped when (io_rd|io_wr) is high and the page is neither a slot page nor CTRL_PAGE.
- An unmapped access sets err.
- ERR_ADDR captures io_addr only if err was 0 before the access, so the first error is kept.

Control registers (page CTRL_PAGE, offset = io_addr[3:0]; other offsets read 0 and ignore writes):
- 0x0 ID, read-only: {8'hA5, NUM_SLOTS[7:0]}.
- 0x2 ERR_ADDR, read-only.
- 0x4 STATUS:
  - bit0 = err; writing 1 to bit0 clears err.
  - bit1 = irq, read-only.
- 0x6 IRQ_MASK: read/write; bits above NUM_SLOTS-1 read 0.
- 0x8 IRQ_PEND: write-1-to-clear per bit.
- 0xA IRQ_ID, read-only: lowest index i with pend[i]&mask[i] set, or 16'hFFFF if none.

Interrupts:
- slot_irq is registered into irq_q.
- pend[i] is set when slot_irq[i] & ~irq_q[i] (rising edge).
- irq = |(pend & mask), driven from registers.

Simultaneous events:
- A new error in the same cycle as an err clear: set wins, and ERR_ADDR is recaptured.
- A pend rising edge in the same cycle as its W1C: set wins.
- A mask write has no effect on pend.

## Timing
- Reset values: err=0, irq=0, ERR_ADDR=0, mask=0, pend=0, irq_q=0.
- Reset is asynchronous. An assertion mid-access aborts any pending register write. The combinational outputs (slot_cs, io_din) are unaffected.
- Reads: io_din is valid in the same cycle as io_rd, with no wait state. This matches J1 sampling.
- Writes commit at the rising edge where io_wr=1.
- err is visible on the output the cycle after the unmapped strobe edge.
- slot_irq rising at edge k (irq_q=0) causes pend, and irq if the slot is unmasked, to be high after edge k.
- A level held high does not re-set pend after a clear. A new 0→1 transition is required.
- If a W1C of the last pending masked bit commits at edge k, irq is 0 after edge k, unless a set occurs at the same edge.

## Configuration
- Macro: IO_FABRIC_IRQ_EN.
- Defined: interrupt logic is present as described above.
- Undefined:
  - irq_q, pend and mask are not built;
  - slot_irq is ignored and irq is tied 0;
  - offsets 0x6, 0x8 and 0xA read 0 and ignore writes; STATUS bit1 reads 0.
- Decode and error capture are identical in both builds.

## Test plan
- Decode sweep: NUM_SLOTS=16, slot i drives 16'h1000+i; read pages 8'h60..8'h6F. Expect slot_cs one-hot on bit i and io_din=16'h1000+i. Page 8'h70 must give io_din=16'h0666 with slot_cs=0.
- Error capture: read 16'h8004, then write 16'h9000. Expect err=1 and ERR_ADDR=16'h8004. Write 1 to STATUS (16'h5F04) → err=0. Unmapped read in the same cycle as the clear write → err stays 1 and ERR_ADDR is recaptured.
- ID: NUM_SLOTS=5, read 16'h5F00 → 16'hA505. Slot page 8'h65 must read 16'h0666 and set err.
- Interrupt: mask=16'h0004, pulse slot_irq[2] → pend=16'h0004, irq=1, IRQ_ID=2. Pulse slot_irq[0] → IRQ_ID stays 2 (bit 0 unmasked? no: masked), pend=16'h0005. W1C 16'h0004 → irq=0.
- Edge semantics: hold slot_irq[3]=1 with mask bit 3 set, clear pend[3] → pend stays 0 until slot_irq[3] falls and rises again. W1C in the same cycle as a new edge → pend bit remains 1.
- Reset mid-operation: with err=1, pend=16'hFFFF and mask=16'hFFFF, assert sys_rst_i between clock edges. All of them go to 0 and irq=0 immediately, without waiting for a clock edge.
- Build check without IO_FABRIC_IRQ_EN: irq=0 under any slot_irq, and reads of 16'h5F06 and 16'h5F0A return 0.
